// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired control sequencer: FSM states, opcodes
// and instruction-field positions.
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      S_RST    = 4'd0,
      S_T0     = 4'd1,
      S_T1     = 4'd2,
      S_T1W    = 4'd3,
      S_T2     = 4'd4,
      S_DEC    = 4'd5,
      S_T3     = 4'd6,
      S_T4     = 4'd7,
      S_T5     = 4'd8,
      S_T6     = 4'd9,
      S_HALTED = 4'd10
   } ctrl_state_t;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHL  = 5'b01000;
   localparam logic [4:0] OP_MUL  = 5'b01010;
   localparam logic [4:0] OP_DIV  = 5'b01011;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int RA_LSB  = 23;
   localparam int RB_LSB  = 19;
   localparam int RC_LSB  = 15;

   function automatic logic is_rfmt(input logic [4:0] opc);
      case (opc)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: return 1'b1;
         default:                                       return 1'b0;
      endcase
   endfunction

   function automatic logic is_muldiv(input logic [4:0] opc);
      return (opc == OP_MUL) || (opc == OP_DIV);
   endfunction

   function automatic logic is_defined(input logic [4:0] opc);
      return is_rfmt(opc) || is_muldiv(opc) || (opc == OP_NOP) || (opc == OP_HALT);
   endfunction

endpackage

// File: rtl/reg_select.sv
// Decodes the Ra/Rb/Rc fields of IR into one-hot general-register load and
// bus-drive selects.
module reg_select
   import cpu_ctrl_pkg::*;
#(
   parameter int RSELW = 4,
   parameter int NREGS = 16
) (
   input  logic [31:0]      IR,
   input  logic             Gra,
   input  logic             Grb,
   input  logic             Grc,
   input  logic             Rin_en,
   input  logic             Rout_en,
   output logic [NREGS-1:0] Rin,
   output logic [NREGS-1:0] Rout
);

   logic [RSELW-1:0] ra;
   logic [RSELW-1:0] rb;
   logic [RSELW-1:0] rc;
   logic             unused_ir_bits;

   assign ra = IR[RA_LSB +: RSELW];
   assign rb = IR[RB_LSB +: RSELW];
   assign rc = IR[RC_LSB +: RSELW];

   assign unused_ir_bits = ^{IR[OPC_MSB:OPC_LSB], IR[RC_LSB-1:0]};

   function automatic logic [NREGS-1:0] onehot(input logic [RSELW-1:0] sel);
      logic [NREGS-1:0] v;
      v      = '0;
      v[sel] = 1'b1;
      return v;
   endfunction

   // Field selects are prioritised so Rout can never be multi-hot.
   always_comb begin
      Rin  = '0;
      Rout = '0;
      if (Rin_en && Gra) begin
         Rin = onehot(ra);
      end
      if (Rout_en) begin
         if (Grb) begin
            Rout = onehot(rb);
         end else if (Grc) begin
            Rout = onehot(rc);
         end else if (Gra) begin
            Rout = onehot(ra);
         end
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit driving the data_path strobes through
// fetch, decode and execute of ALU, MUL/DIV, NOP and HALT instructions.
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int OPW   = 5,
   parameter int RSELW = 4,
   parameter int NREGS = 16
) (
   input  logic             Clock,
   input  logic             clear,
   input  logic [31:0]      IR,
   input  logic             mem_ready,
   output logic             PCout,
   output logic             MDRout,
   output logic             Zhighout,
   output logic             Zlowout,
   output logic             HIout,
   output logic             LOout,
   output logic             PCin,
   output logic             MARin,
   output logic             MDRin,
   output logic             IRin,
   output logic             Yin,
   output logic             ZHighin,
   output logic             Zlowin,
   output logic             HIin,
   output logic             LOin,
   output logic             IncPC,
   output logic             Read,
   output logic [NREGS-1:0] Rin,
   output logic [NREGS-1:0] Rout,
   output logic [OPW-1:0]   op,
   output logic             Run,
   output logic             illegal
);

   ctrl_state_t state;
   ctrl_state_t state_nxt;

   logic [4:0] opc;
   logic       op_rfmt;
   logic       op_md;
   logic       gra;
   logic       grb;
   logic       grc;
   logic       rin_en;
   logic       rout_en;

   assign opc     = IR[OPC_MSB:OPC_LSB];
   assign op_rfmt = is_rfmt(opc);
   assign op_md   = is_muldiv(opc);

   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         state <= S_RST;
      end else begin
         state <= state_nxt;
      end
   end

   // T1W is the memory-wait half of T1: same strobes, minus the PCin pulse.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_RST:  state_nxt = S_T0;
         S_T0:   state_nxt = S_T1;
         S_T1:   state_nxt = mem_ready ? S_T2 : S_T1W;
         S_T1W:  state_nxt = mem_ready ? S_T2 : S_T1W;
         S_T2:   state_nxt = S_DEC;
         S_DEC: begin
            if (op_rfmt || op_md) begin
               state_nxt = S_T3;
            end else if (opc == OP_HALT) begin
               state_nxt = S_HALTED;
            end else begin
               state_nxt = S_T0;
            end
         end
         S_T3:     state_nxt = S_T4;
         S_T4:     state_nxt = S_T5;
         S_T5:     state_nxt = op_md ? S_T6 : S_T0;
         S_T6:     state_nxt = S_T0;
         S_HALTED: state_nxt = S_HALTED;
         default:  state_nxt = S_RST;
      endcase
   end

   always_comb begin
      PCout    = 1'b0;
      MDRout   = 1'b0;
      Zhighout = 1'b0;
      Zlowout  = 1'b0;
      HIout    = 1'b0;
      LOout    = 1'b0;
      PCin     = 1'b0;
      MARin    = 1'b0;
      MDRin    = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      ZHighin  = 1'b0;
      Zlowin   = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      IncPC    = 1'b0;
      Read     = 1'b0;
      op       = '0;
      illegal  = 1'b0;
      gra      = 1'b0;
      grb      = 1'b0;
      grc      = 1'b0;
      rin_en   = 1'b0;
      rout_en  = 1'b0;
      Run      = (state != S_RST) && (state != S_HALTED);
      unique case (state)
         S_T0: begin
            PCout  = 1'b1;
            MARin  = 1'b1;
            IncPC  = 1'b1;
            Zlowin = 1'b1;
            op     = OPW'(OP_ADD);
         end
         S_T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
         end
         S_T1W: begin
            Zlowout = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
         end
         S_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         S_DEC: begin
            illegal = !is_defined(opc);
         end
         S_T3: begin
            grb     = 1'b1;
            rout_en = 1'b1;
            Yin     = 1'b1;
         end
         S_T4: begin
            grc     = 1'b1;
            rout_en = 1'b1;
            op      = OPW'(opc);
            Zlowin  = 1'b1;
            ZHighin = op_md;
         end
         S_T5: begin
            Zlowout = 1'b1;
            if (op_md) begin
               LOin = 1'b1;
            end else begin
               gra    = 1'b1;
               rin_en = 1'b1;
            end
         end
         S_T6: begin
            Zhighout = 1'b1;
            HIin     = 1'b1;
         end
         default: ;
      endcase
   end

   reg_select #(
      .RSELW (RSELW),
      .NREGS (NREGS)
   ) u_reg_select (
      .IR      (IR),
      .Gra     (gra),
      .Grb     (grb),
      .Grc     (grc),
      .Rin_en  (rin_en),
      .Rout_en (rout_en),
      .Rin     (Rin),
      .Rout    (Rout)
   );

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: a per-cycle strobe schedule is derived from each
// instruction and compared against the sequencer outputs cycle by cycle.
module tb_control_sequencer;

   localparam logic [4:0] K_ADD  = 5'b00011;
   localparam logic [4:0] K_MUL  = 5'b01010;
   localparam logic [4:0] K_NOP  = 5'b11010;
   localparam logic [4:0] K_HALT = 5'b11011;

   logic [4:0] alu_ops [6] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000};
   logic [4:0] md_ops  [2] = '{5'b01010, 5'b01011};

   typedef struct packed {
      logic pcout, mdrout, zhighout, zlowout, hiout, loout;
      logic pcin, marin, mdrin, irin, yin, zhighin, zlowin, hiin, loin, incpc, read;
      logic [15:0] rin;
      logic [15:0] rout;
      logic [4:0]  op;
      logic        run;
      logic        illegal;
   } sig_t;

   typedef struct {
      logic [31:0] ir;
      logic        mr;
      sig_t        exp;
   } cyc_t;

   logic        Clock = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] IR = 32'h0;
   logic        mem_ready = 1'b1;
   logic PCout, MDRout, Zhighout, Zlowout, HIout, LOout;
   logic PCin, MARin, MDRin, IRin, Yin, ZHighin, Zlowin, HIin, LOin, IncPC, Read;
   logic [15:0] Rin, Rout;
   logic [4:0]  op;
   logic        Run, illegal;

   sig_t obs;
   cyc_t q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 Clock = ~Clock;

   control_sequencer #(.OPW(5), .RSELW(4), .NREGS(16)) dut (
      .Clock(Clock), .clear(clear), .IR(IR), .mem_ready(mem_ready),
      .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
      .HIout(HIout), .LOout(LOout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
      .IRin(IRin), .Yin(Yin), .ZHighin(ZHighin), .Zlowin(Zlowin), .HIin(HIin),
      .LOin(LOin), .IncPC(IncPC), .Read(Read), .Rin(Rin), .Rout(Rout), .op(op),
      .Run(Run), .illegal(illegal)
   );

   assign obs = {PCout, MDRout, Zhighout, Zlowout, HIout, LOout,
                 PCin, MARin, MDRin, IRin, Yin, ZHighin, Zlowin, HIin, LOin, IncPC, Read,
                 Rin, Rout, op, Run, illegal};

   task automatic check(input string tag, input sig_t got, input sig_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic in_set(input logic [4:0] opc, input logic md);
      if (md) begin
         foreach (md_ops[i]) if (md_ops[i] == opc) return 1'b1;
      end else begin
         foreach (alu_ops[i]) if (alu_ops[i] == opc) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic sig_t busy();
      sig_t s;
      s     = '0;
      s.run = 1'b1;
      return s;
   endfunction

   task automatic push(input logic [31:0] ir, input logic mr, input sig_t s);
      cyc_t c;
      c.ir  = ir;
      c.mr  = mr;
      c.exp = s;
      q.push_back(c);
   endtask

   // Expected output schedule of one instruction, one entry per clock.
   task automatic model_instr(input logic [31:0] ir, input int wait_cyc, input int halt_cyc);
      logic [4:0] opc;
      logic       alu, md;
      sig_t       s;
      opc = ir[31:27];
      alu = in_set(opc, 1'b0);
      md  = in_set(opc, 1'b1);
      s = busy(); s.pcout = 1; s.marin = 1; s.incpc = 1; s.zlowin = 1; s.op = K_ADD;
      push(ir, 1'b1, s);
      for (int k = 0; k <= wait_cyc; k++) begin
         s = busy(); s.zlowout = 1; s.read = 1; s.mdrin = 1; s.pcin = (k == 0);
         push(ir, k == wait_cyc, s);
      end
      s = busy(); s.mdrout = 1; s.irin = 1;
      push(ir, 1'b1, s);
      s = busy(); s.illegal = !(alu || md || opc == K_NOP || opc == K_HALT);
      push(ir, 1'b1, s);
      if (opc == K_HALT) begin
         for (int k = 0; k < halt_cyc; k++) push(ir, 1'b1, sig_t'(0));
      end else if (alu || md) begin
         s = busy(); s.yin = 1; s.rout = 16'(1) << ir[22:19];
         push(ir, 1'b1, s);
         s = busy(); s.zlowin = 1; s.zhighin = md; s.op = opc; s.rout = 16'(1) << ir[18:15];
         push(ir, 1'b1, s);
         s = busy(); s.zlowout = 1;
         if (md) s.loin = 1; else s.rin = 16'(1) << ir[26:23];
         push(ir, 1'b1, s);
         if (md) begin
            s = busy(); s.zhighout = 1; s.hiin = 1;
            push(ir, 1'b1, s);
         end
      end
   endtask

   task automatic run_n(input string tag, input int n);
      cyc_t c;
      for (int k = 0; k < n && q.size() > 0; k++) begin
         c = q.pop_front();
         @(posedge Clock);
         #1;
         IR        = c.ir;
         mem_ready = c.mr;
         @(negedge Clock);
         check(tag, obs, c.exp);
      end
   endtask

   task automatic run_all(input string tag);
      run_n(tag, q.size());
   endtask

   task automatic do_reset(input string tag);
      @(negedge Clock);
      #2 clear = 1'b0;
      #1 check({tag, "_async"}, obs, sig_t'(0));
      @(negedge Clock);
      check({tag, "_hold"}, obs, sig_t'(0));
      clear = 1'b1;
   endtask

   initial begin
      logic [31:0] ir;
      logic [4:0]  opc;
      int          pick;

      repeat (3) @(negedge Clock);
      check("reset", obs, sig_t'(0));
      clear = 1'b1;

      model_instr(32'h18918000, 0, 0);
      run_all("add");
      model_instr(32'h50118000, 0, 0);
      run_all("mul");
      model_instr(32'h18918000, 3, 0);
      run_all("add_wait");
      model_instr(32'hF8000000, 0, 0);
      run_all("illegal");
      model_instr(32'hD0000000, 0, 0);
      run_all("nop");
      model_instr(32'hD8000000, 0, 25);
      run_all("halt");
      do_reset("halt_rst");

      // Abort a MUL in T4: T0, T1, T2, DEC, T3, T4 are the first six entries.
      model_instr(32'h50118000, 0, 0);
      run_n("mul_abort", 6);
      q.delete();
      do_reset("clr_t4");
      model_instr(32'h18918000, 0, 0);
      run_all("post_clr");

      for (int n = 0; n < 60; n++) begin
         pick = $urandom_range(0, 11);
         if (pick < 6) begin
            opc = alu_ops[pick];
         end else if (pick < 8) begin
            opc = md_ops[pick - 6];
         end else if (pick == 8) begin
            opc = K_NOP;
         end else if (pick == 9) begin
            opc = K_HALT;
         end else begin
            do opc = 5'($urandom_range(0, 31));
            while (in_set(opc, 1'b0) || in_set(opc, 1'b1) || opc == K_NOP || opc == K_HALT);
         end
         ir = {opc, 27'($urandom)};
         model_instr(ir, $urandom_range(0, 3), 5);
         run_all("rand");
         if (opc == K_HALT) do_reset("rand_rst");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
